// File: rtl/pipe_pkg.sv
// Shared definitions for the pipe_stage_chain slice: flush-control width helper,
// the largest supported chain depth and the flush-request record.
package pipe_pkg;

    localparam int STAGES_MAX = 8;

    // Width needed to encode a count from 0 up to n inclusive.
    function automatic int dw(input int n);
        return $clog2(n + 1);
    endfunction

    localparam int FLUSH_W = dw(STAGES_MAX);

    typedef struct packed {
        logic               req;
        logic [FLUSH_W-1:0] depth;
        logic [FLUSH_W-1:0] delay;
    } flush_req_t;

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline slot: valid bit plus opaque payload.
// Priority on each edge is kill, then hold, then bubble, then load.
module pipe_stage_reg #(
    parameter int               WIDTH     = 64,
    parameter logic [WIDTH-1:0] NOP_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hold,
    input  logic             kill,
    input  logic             bubble,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= NOP_VALUE;
        end else if (kill) begin
            valid <= 1'b0;
            data  <= NOP_VALUE;
        end else if (hold) begin
            valid <= valid;
            data  <= data;
        end else if (bubble) begin
            valid <= 1'b0;
            data  <= NOP_VALUE;
        end else begin
            valid <= load_valid;
            data  <= load_data;
        end
    end

endmodule

// File: rtl/pipe_stage_chain.sv
// Chain of STAGES register slots with cascading stall, immediate and delayed flush.
// Optional performance counters are enabled with PIPE_STAGE_CHAIN_PERF_EN.
module pipe_stage_chain
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = 64,
    parameter int               STAGES    = 4,
    parameter logic [WIDTH-1:0] NOP_VALUE = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic [WIDTH-1:0]          in_data,
    output logic                      in_ready,
    input  logic [STAGES-1:0]         stall,
    input  logic                      flush_req,
    input  logic [dw(STAGES)-1:0]     flush_depth,
    input  logic [dw(STAGES)-1:0]     flush_delay,
    output logic [STAGES-1:0]         stage_valid,
    output logic [STAGES*WIDTH-1:0]   stage_data,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic                      flush_pending,
    output logic [31:0]               flushed_cnt,
    output logic [31:0]               bubble_cnt
);

    logic [STAGES-1:0] hold;
    logic [STAGES-1:0] kill;
    logic [STAGES-1:0] vld;
    logic [WIDTH-1:0]  dat [STAGES];

    flush_req_t        pend_q;
    logic              fire_req;
    logic              fire_pend;
    logic              flush_now;
    logic [FLUSH_W-1:0] depth_req;
    logic [FLUSH_W-1:0] depth_pend;
    logic [FLUSH_W-1:0] depth_eff;
    logic              hold_acc;

    function automatic logic [FLUSH_W-1:0] clamp_depth(input logic [FLUSH_W-1:0] d);
        return (d > FLUSH_W'(STAGES)) ? FLUSH_W'(STAGES) : d;
    endfunction

    // A stall at stage j freezes every younger stage as well.
    always_comb begin
        hold_acc = 1'b0;
        hold     = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            hold_acc = hold_acc | stall[i];
            hold[i]  = hold_acc;
        end
    end

    always_comb begin
        fire_req   = flush_req && (flush_delay == '0);
        fire_pend  = pend_q.req && (pend_q.delay == '0);
        flush_now  = fire_req || fire_pend;
        depth_req  = fire_req  ? clamp_depth(FLUSH_W'(flush_depth)) : '0;
        depth_pend = fire_pend ? clamp_depth(pend_q.depth)          : '0;
        depth_eff  = (depth_req > depth_pend) ? depth_req : depth_pend;
    end

    assign in_ready = !hold[0] && !flush_now;

    // Delayed flush: a new request always overwrites; the countdown only moves on accepted entries.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q <= '0;
        end else if (flush_req && (flush_delay != '0)) begin
            pend_q.req   <= 1'b1;
            pend_q.depth <= FLUSH_W'(flush_depth);
            pend_q.delay <= FLUSH_W'(flush_delay);
        end else if (fire_pend) begin
            pend_q <= '0;
        end else if (pend_q.req && in_valid && in_ready) begin
            pend_q.delay <= pend_q.delay - 1'b1;
        end
    end

    assign flush_pending = pend_q.req;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic             st_hold;
        logic             st_bubble;
        logic             ld_valid;
        logic [WIDTH-1:0] ld_data;

        if (i == 0) begin : g_head
            assign st_hold   = ~in_ready;
            assign st_bubble = 1'b0;
            assign ld_valid  = in_valid;
            assign ld_data   = in_data;
        end else begin : g_body
            assign st_hold   = hold[i];
            assign st_bubble = hold[i-1] & ~hold[i];
            assign ld_valid  = vld[i-1];
            assign ld_data   = dat[i-1];
        end

        assign kill[i] = flush_now && (FLUSH_W'(i) < depth_eff);

        pipe_stage_reg #(
            .WIDTH     (WIDTH),
            .NOP_VALUE (NOP_VALUE)
        ) u_reg (
            .clk        (clk),
            .reset      (reset),
            .hold       (st_hold),
            .kill       (kill[i]),
            .bubble     (st_bubble),
            .load_valid (ld_valid),
            .load_data  (ld_data),
            .valid      (vld[i]),
            .data       (dat[i])
        );

        assign stage_data[i*WIDTH +: WIDTH] = dat[i];
    end

    assign stage_valid = vld;
    assign out_valid   = vld[STAGES-1];
    assign out_data    = dat[STAGES-1];

`ifdef PIPE_STAGE_CHAIN_PERF_EN
    logic [31:0] flushed_q;
    logic [31:0] bubble_q;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? '1 : s[31:0];
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flushed_q <= '0;
            bubble_q  <= '0;
        end else begin
            flushed_q <= sat_add(flushed_q, 32'($countones(vld & kill)));
            bubble_q  <= sat_add(bubble_q, {31'd0, ~out_valid});
        end
    end

    assign flushed_cnt = flushed_q;
    assign bubble_cnt  = bubble_q;
`else
    assign flushed_cnt = '0;
    assign bubble_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Self-checking bench for pipe_stage_chain (STAGES=4, WIDTH=16) against a
// per-cycle behavioural model of the chain; honours PIPE_STAGE_CHAIN_PERF_EN.
module tb_pipe_stage_chain;

    localparam int           W   = 16;
    localparam int           S   = 4;
    localparam int           DWL = $clog2(S + 1);
    localparam logic [W-1:0] NOP = 16'h5A5A;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic [W-1:0]     in_data;
    logic             in_ready;
    logic [S-1:0]     stall;
    logic             flush_req;
    logic [DWL-1:0]   flush_depth;
    logic [DWL-1:0]   flush_delay;
    logic [S-1:0]     stage_valid;
    logic [S*W-1:0]   stage_data;
    logic             out_valid;
    logic [W-1:0]     out_data;
    logic             flush_pending;
    logic [31:0]      flushed_cnt;
    logic [31:0]      bubble_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference state
    logic         mv [S];
    logic [W-1:0] md [S];
    logic         mpend;
    int           mcnt;
    int           mdepth;
    logic [31:0]  mfl;
    logic [31:0]  mbb;
    logic         mh [S];
    logic         mready;
    logic         mfnow;
    int           mD;

    pipe_stage_chain #(.WIDTH(W), .STAGES(S), .NOP_VALUE(NOP)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .stall         (stall),
        .flush_req     (flush_req),
        .flush_depth   (flush_depth),
        .flush_delay   (flush_delay),
        .stage_valid   (stage_valid),
        .stage_data    (stage_data),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .flush_pending (flush_pending),
        .flushed_cnt   (flushed_cnt),
        .bubble_cnt    (bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < S; i++) begin
            mv[i] = 1'b0;
            md[i] = NOP;
        end
        mpend = 1'b0; mcnt = 0; mdepth = 0; mfl = 0; mbb = 0;
    endtask

    function automatic logic [31:0] sat(input logic [31:0] a, input int b);
        longint s;
        s = longint'(a) + longint'(b);
        return (s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    task automatic model_comb();
        logic h;
        int dr, dp;
        h = 1'b0;
        for (int i = S - 1; i >= 0; i--) begin
            h = h | stall[i];
            mh[i] = h;
        end
        dr = (flush_req && flush_delay == 0) ? int'(flush_depth) : 0;
        dp = (mpend && mcnt == 0) ? mdepth : 0;
        if (dr > S) dr = S;
        if (dp > S) dp = S;
        mfnow  = (flush_req && flush_delay == 0) || (mpend && mcnt == 0);
        mD     = (dr > dp) ? dr : dp;
        mready = !mh[0] && !mfnow;
    endtask

    task automatic model_edge();
        logic         nv [S];
        logic [W-1:0] nd [S];
        int kills;
        kills = 0;
        for (int i = 0; i < S; i++) begin
            if (mfnow && i < mD) begin
                nv[i] = 1'b0; nd[i] = NOP;
                if (mv[i]) kills++;
            end else if (i == 0) begin
                nv[i] = mready ? in_valid : mv[i];
                nd[i] = mready ? in_data  : md[i];
            end else if (mh[i]) begin
                nv[i] = mv[i]; nd[i] = md[i];
            end else if (mh[i-1]) begin
                nv[i] = 1'b0; nd[i] = NOP;
            end else begin
                nv[i] = mv[i-1]; nd[i] = md[i-1];
            end
        end
`ifdef PIPE_STAGE_CHAIN_PERF_EN
        mfl = sat(mfl, kills);
        mbb = sat(mbb, mv[S-1] ? 0 : 1);
`endif
        if (flush_req && flush_delay != 0) begin
            mpend = 1'b1; mcnt = int'(flush_delay); mdepth = int'(flush_depth);
        end else if (mpend && mcnt == 0) begin
            mpend = 1'b0; mcnt = 0; mdepth = 0;
        end else if (mpend && in_valid && mready) begin
            mcnt--;
        end
        for (int i = 0; i < S; i++) begin
            mv[i] = nv[i]; md[i] = nd[i];
        end
    endtask

    task automatic check_regs();
        for (int i = 0; i < S; i++) begin
            chk($sformatf("stage_valid[%0d]", i), 64'(stage_valid[i]), 64'(mv[i]));
            chk($sformatf("stage_data[%0d]", i), 64'(stage_data[i*W +: W]), 64'(md[i]));
        end
        chk("out_valid", 64'(out_valid), 64'(mv[S-1]));
        chk("out_data", 64'(out_data), 64'(md[S-1]));
        chk("flush_pending_q", 64'(flush_pending), 64'(mpend));
        chk("flushed_cnt", 64'(flushed_cnt), 64'(mfl));
        chk("bubble_cnt", 64'(bubble_cnt), 64'(mbb));
    endtask

    task automatic step(input logic [S-1:0] st, input logic iv, input logic [W-1:0] id,
                        input logic fr, input int fd, input int fdl);
        stall = st; in_valid = iv; in_data = id;
        flush_req = fr; flush_depth = DWL'(fd); flush_delay = DWL'(fdl);
        #1;
        model_comb();
        chk("in_ready", 64'(in_ready), 64'(mready));
        chk("flush_pending", 64'(flush_pending), 64'(mpend));
        @(posedge clk);
        model_edge();
        #1;
        check_regs();
    endtask

    task automatic check_reset_state();
        chk("rst_stage_valid", 64'(stage_valid), 64'(0));
        for (int i = 0; i < S; i++)
            chk($sformatf("rst_stage_data[%0d]", i), 64'(stage_data[i*W +: W]), 64'(NOP));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_flush_pending", 64'(flush_pending), 64'(0));
        chk("rst_flushed_cnt", 64'(flushed_cnt), 64'(0));
        chk("rst_bubble_cnt", 64'(bubble_cnt), 64'(0));
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; stall = '0;
        flush_req = 1'b0; flush_depth = '0; flush_delay = '0;
        model_reset();
        #2;
        check_reset_state();
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        #2 reset = 1'b0;

        // Stream A1..A6 with no stall; A1 reaches out_data four edges after its push
        for (int k = 0; k < 6; k++) begin
            step('0, 1'b1, 16'(16'hA1 + k), 1'b0, 0, 0);
            if (k == 3) chk("latency_a1", 64'(out_data), 64'(16'hA1));
        end
        for (int k = 0; k < 4; k++) step('0, 1'b0, 16'h0, 1'b0, 0, 0);

        // Refill, then stall stage 1 for two cycles while pushing
        for (int k = 0; k < 4; k++) step('0, 1'b1, 16'(16'hB0 + k), 1'b0, 0, 0);
        step(4'b0010, 1'b1, 16'hB8, 1'b0, 0, 0);
        chk("stall_in_ready", 64'(in_ready), 64'(0));
        step(4'b0010, 1'b1, 16'hB8, 1'b0, 0, 0);
        chk("stall_bubble_s2", 64'(stage_valid[2]), 64'(0));
        for (int k = 0; k < 4; k++) step('0, 1'b1, 16'(16'hC0 + k), 1'b0, 0, 0);

        // Immediate flush depth 2 with a full chain
        step('0, 1'b1, 16'hD0, 1'b1, 2, 0);
        chk("flush_s01", 64'(stage_valid[1:0]), 64'(0));

        // No-op flush (depth 0) and an over-range depth that clamps to the full chain
        for (int k = 0; k < 4; k++) step('0, 1'b1, 16'(16'hD1 + k), 1'b0, 0, 0);
        step('0, 1'b1, 16'hD8, 1'b1, 0, 0);
        step('0, 1'b1, 16'hD9, 1'b1, 7, 0);
        chk("flush_all", 64'(stage_valid), 64'(0));

        // Delayed flush depth 3 delay 1: one accepted push, then it fires
        for (int k = 0; k < 4; k++) step('0, 1'b1, 16'(16'hE0 + k), 1'b0, 0, 0);
        step('0, 1'b1, 16'hE4, 1'b1, 3, 1);
        step('0, 1'b1, 16'hE5, 1'b0, 0, 0);
        step('0, 1'b1, 16'hE6, 1'b0, 0, 0);
        chk("dflush_s012", 64'(stage_valid[2:0]), 64'(0));
        chk("dflush_drop", 64'(flush_pending), 64'(0));

        // Pending (depth 1) and immediate (depth 3) fire together
        for (int k = 0; k < 4; k++) step('0, 1'b1, 16'(16'hF0 + k), 1'b0, 0, 0);
        step('0, 1'b1, 16'hF4, 1'b1, 1, 1);
        step('0, 1'b1, 16'hF5, 1'b0, 0, 0);
        step('0, 1'b1, 16'hF6, 1'b1, 3, 0);
        chk("simul_s012", 64'(stage_valid[2:0]), 64'(0));

        // Randomized traffic
        for (int k = 0; k < 300; k++) begin
            logic [S-1:0] st;
            st = ($urandom_range(0, 5) == 0) ? S'($urandom) : '0;
            step(st, 1'($urandom), 16'($urandom), ($urandom_range(0, 7) == 0),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
        end

        // Reset asserted mid-stream, away from the edge, with a flush pending
        for (int k = 0; k < 3; k++) step('0, 1'b1, 16'(16'h7700 + k), 1'b0, 0, 0);
        step('0, 1'b1, 16'h7710, 1'b1, 2, 3);
        step('0, 1'b0, 16'h0, 1'b0, 0, 0);
        #2 reset = 1'b1;
        #1;
        check_reset_state();
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 40; k++)
            step('0, 1'($urandom), 16'($urandom), ($urandom_range(0, 9) == 0),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
